cpc_rom_loader: RTL and testbench

//  Buffers the ROM download byte stream from mist_io (ioctl_*) and writes it into SDRAM at the CPC ROM page slots.

---
 rtl/cpc_rom_loader.sv | 151 +++++++++++++++
 tb/tb_cpc_rom_loader.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_rom_loader.sv
// CPC ROM download loader: maps ioctl bytes to SDRAM ROM slots, queues them in a small FIFO
// and writes them via a boot_wr/boot_ack handshake. Optional checksum output under AMSTRAD_ROM_SUM_EN.
module cpc_rom_loader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        boot_ack,
    output logic        boot_wr,
    output logic [22:0] boot_a,
    output logic [1:0]  boot_bank,
    output logic [7:0]  boot_dout,
    output logic        load_reset,
    output logic        load_done,
    output logic        overflow,
    output logic [15:0] dropped
`ifdef AMSTRAD_ROM_SUM_EN
    ,
    output logic [15:0] rom_sum
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 33;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            boot_wr_q;
    logic [22:0]     boot_a_q;
    logic [1:0]      boot_bank_q;
    logic [7:0]      boot_dout_q;
    logic            overflow_q;
    logic [15:0]     dropped_q;

    logic            rom_dl, in_range, byte_ok, drop_hit, over_hit;
    logic            full, empty, push, pop, start_load;
    logic [10:0]     page;
    logic [8:0]      slot;
    logic [EW-1:0]   push_entry;

    assign rom_dl   = ioctl_download && (ioctl_index == 8'd0);
    assign page     = ioctl_addr[24:14];
    assign in_range = (page[10:3] == 8'd0);
    assign byte_ok  = ioctl_wr && rom_dl && in_range;
    assign drop_hit = ioctl_wr && rom_dl && !in_range;

    // Pages 4-7 reuse the slot map of pages 0-3 in bank 1.
    always_comb begin
        case (page[1:0])
            2'd0:    slot = 9'h000;
            2'd1:    slot = 9'h100;
            2'd2:    slot = 9'h107;
            default: slot = 9'h1FF;
        endcase
    end

    assign push_entry = {slot, ioctl_addr[13:0], 1'b0, page[2], ioctl_dout};

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !boot_wr_q && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
    assign push     = byte_ok && (!full || pop);
    assign over_hit = byte_ok && full && !pop;
    assign count_d  = count_q + CW'(push) - CW'(pop);

    assign start_load = (state_q == S_IDLE) && rom_dl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rom_dl) state_d = S_LOAD;
            S_LOAD:  if (!rom_dl) state_d = S_DRAIN;
            S_DRAIN: begin
                if (rom_dl)                  state_d = S_LOAD;
                else if (empty && !boot_wr_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            boot_wr_q   <= 1'b0;
            boot_a_q    <= '0;
            boot_bank_q <= '0;
            boot_dout_q <= '0;
            overflow_q  <= 1'b0;
            dropped_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                boot_a_q    <= mem_q[rd_ptr_q][32:10];
                boot_bank_q <= mem_q[rd_ptr_q][9:8];
                boot_dout_q <= mem_q[rd_ptr_q][7:0];
                boot_wr_q   <= 1'b1;
            end else if (boot_ack) begin
                boot_wr_q <= 1'b0;
            end
            if (start_load)    overflow_q <= over_hit;
            else if (over_hit) overflow_q <= 1'b1;
            if (start_load)
                dropped_q <= {15'd0, drop_hit};
            else if (drop_hit && (dropped_q != 16'hFFFF))
                dropped_q <= dropped_q + 16'd1;
        end
    end

`ifdef AMSTRAD_ROM_SUM_EN
    logic [15:0] rom_sum_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)                      rom_sum_q <= '0;
        else if (start_load)            rom_sum_q <= '0;
        else if (boot_wr_q && boot_ack) rom_sum_q <= rom_sum_q + {8'd0, boot_dout_q};
    end

    assign rom_sum = rom_sum_q;
`endif

    assign boot_wr    = boot_wr_q;
    assign boot_a     = boot_a_q;
    assign boot_bank  = boot_bank_q;
    assign boot_dout  = boot_dout_q;
    assign load_reset = (state_q != S_IDLE);
    assign load_done  = (state_q == S_DONE);
    assign overflow   = overflow_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_cpc_rom_loader.sv
// Bench for cpc_rom_loader: directed scenarios plus randomized bursts checked against a
// queue-based model of the page map. Define AMSTRAD_ROM_SUM_EN to also check rom_sum.
module tb_cpc_rom_loader;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        boot_ack = 1'b0;
    logic        boot_wr;
    logic [22:0] boot_a;
    logic [1:0]  boot_bank;
    logic [7:0]  boot_dout;
    logic        load_reset, load_done, overflow;
    logic [15:0] dropped;
`ifdef AMSTRAD_ROM_SUM_EN
    logic [15:0] rom_sum;
`endif

    cpc_rom_loader #(.FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .boot_ack(boot_ack),
        .boot_wr(boot_wr), .boot_a(boot_a), .boot_bank(boot_bank), .boot_dout(boot_dout),
        .load_reset(load_reset), .load_done(load_done), .overflow(overflow), .dropped(dropped)
`ifdef AMSTRAD_ROM_SUM_EN
        , .rom_sum(rom_sum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int passes = 0;
    logic [32:0] exp_q [$];
    logic [32:0] obs_q [$];
    int exp_drop = 0;
    bit ack_hold = 1'b0;
    int ack_wait = 0;
    int unstable = 0;
    int gap_err = 0;

    // Reference map: 16 KiB pages, pages 0-3 to slots 000/100/107/1FF, pages 4-7 same slots in bank 1.
    function automatic logic [32:0] model_map(input logic [24:0] addr, input logic [7:0] data);
        int unsigned page = addr / 16384;
        int unsigned slot;
        int unsigned byte_a;
        case (page % 4)
            0: slot = 0;
            1: slot = 256;
            2: slot = 263;
            default: slot = 511;
        endcase
        byte_a = slot * 16384 + (addr % 16384);
        return {23'(byte_a), 2'(page / 4), data};
    endfunction

    // SDRAM side: acks each write after ack_wait cycles, records it, checks stability and the gap.
    initial begin
        bit in_wr = 1'b0;
        int wait_cnt = 0;
        logic [32:0] held = '0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (reset) begin
                boot_ack = 1'b0;
                in_wr = 1'b0;
            end else if (boot_ack) begin
                boot_ack = 1'b0;
                if (boot_wr) gap_err++;
            end else if (boot_wr) begin
                if (!in_wr) begin
                    in_wr = 1'b1;
                    held = {boot_a, boot_bank, boot_dout};
                    wait_cnt = 0;
                end else if ({boot_a, boot_bank, boot_dout} !== held) begin
                    unstable++;
                end
                if (!ack_hold && wait_cnt >= ack_wait) begin
                    boot_ack = 1'b1;
                    obs_q.push_back(held);
                    in_wr = 1'b0;
                    $display("write a=%06h bank=%0d data=%02h", held[32:10], held[9:8], held[7:0]);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic wr_byte(input logic [24:0] addr, input logic [7:0] data);
        if (ioctl_download && ioctl_index == 8'd0) begin
            if (addr / 16384 < 8) exp_q.push_back(model_map(addr, data));
            else exp_drop++;
        end
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_load();
        obs_q.delete();
        exp_q.delete();
        exp_drop = 0;
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic finish_load(output bit ok);
        ioctl_download = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (load_done) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({boot_wr, boot_a, boot_bank, boot_dout, load_reset, load_done, overflow, dropped} !== '0)
            $display("FAIL reset_outputs: got wr=%b a=%h bank=%h d=%h lr=%b ld=%b ov=%b dr=%h, expected all 0",
                     boot_wr, boot_a, boot_bank, boot_dout, load_reset, load_done, overflow, dropped);
        else passes++;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (load_reset !== 1'b0 || boot_wr !== 1'b0)
            $display("FAIL idle_after_reset: got lr=%b wr=%b, expected 0 0", load_reset, boot_wr);
        else passes++;
    endtask

    task automatic test_stream();
        bit ok;
        ack_hold = 1'b0;
        ack_wait = 0;
        start_load();
        checks++;
        if (load_reset !== 1'b1) $display("FAIL stream_load_reset: got %b expected 1", load_reset);
        else passes++;
        for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'(8'hA0 + i));
        finish_load(ok);
        checks++;
        if (!ok || obs_q.size() != 4) $display("FAIL stream_count: done=%b writes=%0d expected 4", ok, obs_q.size());
        else passes++;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== {23'(i), 2'd0, 8'(8'hA0 + i)})
                $display("FAIL stream_write%0d: got %h expected %h", i, obs_q[i], {23'(i), 2'd0, 8'(8'hA0 + i)});
            else passes++;
        end
    endtask

    task automatic test_page_map();
        bit ok;
        logic [24:0] addrs [4] = '{25'h04000, 25'h08000, 25'h0C000, 25'h10000};
        logic [24:0] want_a [4] = '{25'h400000, 25'h41C000, 25'h7FC000, 25'h000000};
        logic [1:0]  want_b [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
        ack_wait = 1;
        start_load();
        for (int i = 0; i < 4; i++) begin
            wr_byte(addrs[i], 8'(8'h10 + i));
            tick();
        end
        finish_load(ok);
        checks++;
        if (!ok || obs_q.size() != 4) $display("FAIL map_count: done=%b writes=%0d expected 4", ok, obs_q.size());
        else passes++;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== {want_a[i][22:0], want_b[i], 8'(8'h10 + i)})
                $display("FAIL map_page%0d: got a=%h bank=%0d expected a=%h bank=%0d",
                         i + 1, obs_q[i][32:10], obs_q[i][9:8], want_a[i][22:0], want_b[i]);
            else passes++;
        end
    endtask

    task automatic test_overflow();
        bit ok;
        ack_hold = 1'b1;
        ack_wait = 0;
        start_load();
        for (int i = 0; i < 5; i++) wr_byte(25'(16'h0100 + i), 8'(8'hC0 + i));
        checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_before_full: got %b expected 0", overflow);
        else passes++;
        wr_byte(25'h00105, 8'hC5);
        void'(exp_q.pop_back());  // sixth byte finds the FIFO full and is lost
        tick();
        tick();
        checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow);
        else passes++;
        checks++;
        if (boot_wr !== 1'b1 || {boot_a, boot_bank, boot_dout} !== exp_q[0])
            $display("FAIL ovf_head_held: got wr=%b %h expected wr=1 %h", boot_wr, {boot_a, boot_bank, boot_dout}, exp_q[0]);
        else passes++;
        ack_hold = 1'b0;
        finish_load(ok);
        checks++;
        if (!ok || obs_q.size() != 5) $display("FAIL ovf_count: done=%b writes=%0d expected 5", ok, obs_q.size());
        else passes++;
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL ovf_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            else passes++;
        end
        checks++;
        if (overflow !== 1'b1 || unstable != 0)
            $display("FAIL ovf_sticky_stable: got ov=%b unstable=%0d expected 1 0", overflow, unstable);
        else passes++;
    endtask

    task automatic test_drop();
        bit ok;
        start_load();
        checks++;
        if (overflow !== 1'b0 || dropped !== 16'd0)
            $display("FAIL drop_cleared: got ov=%b dr=%0d expected 0 0", overflow, dropped);
        else passes++;
        wr_byte(25'h20000, 8'h55);
        tick();
        tick();
        tick();
        checks++;
        if (dropped !== 16'd1 || boot_wr !== 1'b0 || obs_q.size() != 0)
            $display("FAIL drop_page8: got dr=%0d wr=%b writes=%0d expected 1 0 0", dropped, boot_wr, obs_q.size());
        else passes++;
        finish_load(ok);
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        for (int i = 0; i < 3; i++) wr_byte(25'(i), 8'(i));
        wr_byte(25'h20000, 8'h77);
        tick();
        tick();
        checks++;
        if (load_reset !== 1'b0 || boot_wr !== 1'b0 || obs_q.size() != 0 || dropped !== 16'd1)
            $display("FAIL index1_ignored: got lr=%b wr=%b writes=%0d dr=%0d expected 0 0 0 1",
                     load_reset, boot_wr, obs_q.size(), dropped);
        else passes++;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        tick();
    endtask

    task automatic test_drain_done();
        bit lr_ok = 1'b1;
        bit hit = 1'b0;
        ack_hold = 1'b1;
        ack_wait = 0;
        start_load();
        for (int i = 0; i < 3; i++) wr_byte(25'(i), 8'(8'h30 + i));
        ioctl_download = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (load_reset !== 1'b1 || load_done !== 1'b0)
            $display("FAIL drain_hold: got lr=%b ld=%b expected 1 0", load_reset, load_done);
        else passes++;
        ack_hold = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (load_reset !== 1'b1) lr_ok = 1'b0;
            if (obs_q.size() == 3) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || !lr_ok) $display("FAIL drain_third_ack: got seen=%b lr_held=%b expected 1 1", hit, lr_ok);
        else passes++;
        tick();
        checks++;
        if (load_reset !== 1'b1 || load_done !== 1'b0)
            $display("FAIL drain_ack_plus1: got lr=%b ld=%b expected 1 0", load_reset, load_done);
        else passes++;
        tick();
        checks++;
        if (load_reset !== 1'b1 || load_done !== 1'b1)
            $display("FAIL drain_ack_plus2: got lr=%b ld=%b expected 1 1", load_reset, load_done);
        else passes++;
        tick();
        checks++;
        if (load_reset !== 1'b0 || load_done !== 1'b0)
            $display("FAIL drain_ack_plus3: got lr=%b ld=%b expected 0 0", load_reset, load_done);
        else passes++;
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        bit quiet = 1'b1;
        ack_hold = 1'b1;
        start_load();
        wr_byte(25'h0, 8'h11);
        wr_byte(25'h1, 8'h22);
        tick();
        checks++;
        if (boot_wr !== 1'b1) $display("FAIL rst_pre_wr: got %b expected 1", boot_wr);
        else passes++;
        #3 reset = 1'b1;
        #1;
        checks++;
        if (boot_wr !== 1'b0 || load_reset !== 1'b0)
            $display("FAIL rst_async: got wr=%b lr=%b expected 0 0", boot_wr, load_reset);
        else passes++;
        obs_q.delete();
        exp_q.delete();
        tick();
        tick();
        #3 reset = 1'b0;
        tick();
        checks++;
        if (load_reset !== 1'b1) $display("FAIL rst_reenter_load: got %b expected 1", load_reset);
        else passes++;
        ack_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (boot_wr !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || obs_q.size() != 0) $display("FAIL rst_fifo_flushed: got quiet=%b writes=%0d expected 1 0", quiet, obs_q.size());
        else passes++;
        wr_byte(25'h0, 8'h01);
        wr_byte(25'h1, 8'hFF);
        wr_byte(25'h2, 8'h80);
        finish_load(ok);
        checks++;
        if (!ok || obs_q.size() != 3 || obs_q[0] !== exp_q[0] || obs_q[2] !== exp_q[2])
            $display("FAIL rst_fresh_load: done=%b writes=%0d expected 1 3 matching", ok, obs_q.size());
        else passes++;
`ifdef AMSTRAD_ROM_SUM_EN
        checks++;
        if (rom_sum !== 16'h0180) $display("FAIL rom_sum: got %h expected 0180", rom_sum);
        else passes++;
`endif
    endtask

    task automatic test_random();
        for (int run = 0; run < 2; run++) begin
            bit ok;
            bit drained;
            start_load();
            for (int b = 0; b < 12; b++) begin
                int len = $urandom_range(1, 5);
                ack_wait = $urandom_range(0, 3);
                for (int k = 0; k < len; k++) begin
                    int unsigned pg = $urandom_range(0, 9);
                    int unsigned off = $urandom_range(0, 16383);
                    wr_byte(25'(pg * 16384 + off), 8'($urandom));
                end
                drained = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    tick();
                    if (obs_q.size() == exp_q.size() && !boot_wr) begin
                        drained = 1'b1;
                        break;
                    end
                end
                checks++;
                if (!drained) $display("FAIL rand_drain: writes=%0d expected %0d", obs_q.size(), exp_q.size());
                else passes++;
            end
            finish_load(ok);
            checks++;
            if (!ok || obs_q.size() != exp_q.size())
                $display("FAIL rand_count: done=%b writes=%0d expected %0d", ok, obs_q.size(), exp_q.size());
            else passes++;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL rand_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
                else passes++;
            end
            checks++;
            if (dropped !== 16'(exp_drop) || overflow !== 1'b0)
                $display("FAIL rand_counters: got dr=%0d ov=%b expected %0d 0", dropped, overflow, exp_drop);
            else passes++;
        end
        checks++;
        if (unstable != 0 || gap_err != 0)
            $display("FAIL handshake_rules: got unstable=%0d gap=%0d expected 0 0", unstable, gap_err);
        else passes++;
    endtask

    initial begin
        #3;
        test_reset();
        test_stream();
        test_page_map();
        test_overflow();
        test_drop();
        test_drain_done();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
